// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll sequencer: die encodings, side counts, FSM states.
package dice_pkg;

  localparam int unsigned DIE_W = 2;
  localparam int unsigned VAL_W = 8;

  localparam logic [DIE_W-1:0] DIE_D4  = 2'b00;
  localparam logic [DIE_W-1:0] DIE_D6  = 2'b01;
  localparam logic [DIE_W-1:0] DIE_D8  = 2'b10;
  localparam logic [DIE_W-1:0] DIE_D20 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } seq_state_e;

  function automatic logic [VAL_W-1:0] sides_of(input logic [DIE_W-1:0] die);
    logic [VAL_W-1:0] sides;
    case (die)
      DIE_D4:  sides = VAL_W'(4);
      DIE_D6:  sides = VAL_W'(6);
      DIE_D8:  sides = VAL_W'(8);
      default: sides = VAL_W'(20);
    endcase
    return sides;
  endfunction

endpackage

// File: rtl/dice_roll_sequencer_if.sv
// Command and result handshake bundle between control logic (master) and the sequencer (slave).
interface dice_roll_sequencer_if #(
  parameter int unsigned COUNT_W = 4,
  parameter int unsigned SUM_W   = 12
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_die;
  logic [COUNT_W-1:0] cmd_count;
  logic               res_valid;
  logic               res_ready;
  logic [SUM_W-1:0]   res_sum;
  logic [7:0]         res_min;
  logic [7:0]         res_max;
  logic               res_err;

  modport master (
    output cmd_valid, cmd_die, cmd_count, res_ready,
    input  cmd_ready, res_valid, res_sum, res_min, res_max, res_err
  );

  modport slave (
    input  cmd_valid, cmd_die, cmd_count, res_ready,
    output cmd_ready, res_valid, res_sum, res_min, res_max, res_err
  );
endinterface

// File: rtl/dice_stats_acc.sv
// Running sum (saturating), min, max and optional out-of-range flag for one command.
// Range checking is built only when DICE_RANGE_CHECK_EN is defined.
module dice_stats_acc
  import dice_pkg::*;
#(
  parameter int unsigned SUM_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             capture,
  input  logic [VAL_W-1:0] value,
  input  logic [DIE_W-1:0] die,
  output logic [SUM_W-1:0] sum,
  output logic [VAL_W-1:0] min,
  output logic [VAL_W-1:0] max,
  output logic             err
);
  localparam int unsigned EXT_W = SUM_W + 1;

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [VAL_W-1:0] min_q, min_d;
  logic [VAL_W-1:0] max_q, max_d;
  logic [EXT_W-1:0] sum_ext;

  // One extra bit catches the carry so the sum can clamp instead of wrapping.
  assign sum_ext = EXT_W'(sum_q) + EXT_W'(value);

  always_comb begin
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    if (clear) begin
      sum_d = '0;
      min_d = '1;
      max_d = '0;
    end else if (capture) begin
      sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      if (value < min_q) min_d = value;
      if (value > max_q) max_d = value;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign sum = sum_q;
  assign min = min_q;
  assign max = max_q;

`ifdef DICE_RANGE_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (capture && ((value == '0) || (value > sides_of(die)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_die;
  assign unused_die = ^die;
  assign err        = 1'b0;
`endif

endmodule

// File: rtl/dice_roll_sequencer.sv
// Drives dice_roller one roll at a time for an N-dice command and returns sum/min/max.
// Optional range checking of each roll is enabled by defining DICE_RANGE_CHECK_EN.
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int unsigned COUNT_W      = 4,
  parameter int unsigned SUM_W        = 12,
  parameter int unsigned ROLL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dice_roll_sequencer_if.slave  bus,
  output logic                  roll,
  output logic [DIE_W-1:0]      die_select,
  input  logic [VAL_W-1:0]      rolled_number
);
  localparam int unsigned WAIT_W = 3;
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(ROLL_LATENCY - 1);

  seq_state_e state_q, state_d;

  logic [DIE_W-1:0]   die_q, die_d;
  logic [COUNT_W-1:0] left_q, left_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               zero_q, zero_d;
  logic               roll_q, roll_d;
  logic               rdy_q, rdy_d;
  logic               valid_q, valid_d;
  logic [SUM_W-1:0]   res_sum_q;
  logic [VAL_W-1:0]   res_min_q, res_max_q;
  logic               res_err_q;

  logic               acc_clear, acc_cap, load_res;
  logic [SUM_W-1:0]   acc_sum;
  logic [VAL_W-1:0]   acc_min, acc_max;
  logic               acc_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    die_d     = die_q;
    left_d    = left_q;
    wait_d    = wait_q;
    zero_d    = zero_q;
    acc_clear = 1'b0;
    acc_cap   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && rdy_q) begin
          die_d     = bus.cmd_die;
          left_d    = bus.cmd_count;
          zero_d    = (bus.cmd_count == '0);
          acc_clear = 1'b1;
          state_d   = (bus.cmd_count == '0) ? S_DONE : S_STROBE;
        end
      end
      S_STROBE: begin
        wait_d  = WAIT_RELOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_CAPTURE;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_CAPTURE: begin
        acc_cap = 1'b1;
        left_d  = left_q - COUNT_W'(1);
        state_d = (left_q == COUNT_W'(1)) ? S_DONE : S_STROBE;
      end
      S_DONE: begin
        if (valid_q && bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state; res_valid trails DONE entry by one
    // cycle so the result registers are loaded before it is presented.
    roll_d   = (state_d == S_STROBE);
    rdy_d    = (state_d == S_IDLE);
    valid_d  = (state_q == S_DONE) && (state_d == S_DONE);
    load_res = (state_q == S_DONE) && !valid_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      die_q     <= DIE_D4;
      left_q    <= '0;
      wait_q    <= '0;
      zero_q    <= 1'b0;
      roll_q    <= 1'b0;
      rdy_q     <= 1'b1;
      valid_q   <= 1'b0;
      res_sum_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
      res_err_q <= 1'b0;
    end else begin
      die_q   <= die_d;
      left_q  <= left_d;
      wait_q  <= wait_d;
      zero_q  <= zero_d;
      roll_q  <= roll_d;
      rdy_q   <= rdy_d;
      valid_q <= valid_d;
      if (load_res) begin
        res_sum_q <= acc_sum;
        res_min_q <= zero_q ? '0 : acc_min;
        res_max_q <= acc_max;
        res_err_q <= acc_err;
      end
    end
  end

  dice_stats_acc #(.SUM_W(SUM_W)) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (acc_clear),
    .capture (acc_cap),
    .value   (rolled_number),
    .die     (die_q),
    .sum     (acc_sum),
    .min     (acc_min),
    .max     (acc_max),
    .err     (acc_err)
  );

  assign roll          = roll_q;
  assign die_select    = die_q;
  assign bus.cmd_ready = rdy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_min   = res_min_q;
  assign bus.res_max   = res_max_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: doc/dice_roll_sequencer.md
# dice_roll_sequencer

Initiator-side companion to `dice_roller`. It accepts a "roll N dice of type D" command and drives `dice_roller` through its `roll`/`die_select` inputs one roll at a time. It captures each `rolled_number` and returns the total, minimum and maximum through a valid/ready result port. It sits between the game/control logic and `dice_roller` and is the only driver of that block's inputs.

## Interface
- `COUNT_W`, default 4: width of the dice-count field. Maximum of 2^COUNT_W−1 dice per command.
- `SUM_W`, default 12: width of the accumulated sum. Must hold (2^COUNT_W−1)×20.
- `ROLL_LATENCY`, default 1: cycles from a sampled `roll`=1 to a valid `rolled_number`. Legal range 1..7.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_die` in 2: die type. 00=d4, 01=d6, 10=d8, 11=d20.
- `cmd_count` in COUNT_W: number of dice to roll.
- `roll` out 1: roll strobe to `dice_roller`.
- `die_select` out 2: die type to `dice_roller`.
- `rolled_number` in 8: result from `dice_roller`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_sum` out SUM_W: sum of all rolls.
- `res_min` out 8: smallest roll in the command.
- `res_max` out 8: largest roll in the command.
- `res_err` out 1: at least one roll was out of range. Only driven when `DICE_RANGE_CHECK_EN` is defined; otherwise tied to 0.

## Operation
- States: IDLE, STROBE, WAIT, CAPTURE, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: latch `cmd_die` and `cmd_count`; clear the accumulator; set min=8'hFF, max=0, err=0.
  - If count=0, go straight to DONE with sum=0, min=0, max=0. Otherwise go to STROBE.
- **STROBE**
  - `roll`=1 for exactly one cycle.
  - `die_select` holds the latched die for the whole command, from the accept cycle until DONE exits.
  - Reload the wait counter with ROLL_LATENCY−1, then go to WAIT.
- **WAIT**
  - Count down; go to CAPTURE when the counter is 0.
  - With ROLL_LATENCY=1 the sequencer passes through WAIT for one cycle.
- **CAPTURE**
  - Add zero-extended `rolled_number` to the sum.
  - Update min and max.
  - Decrement the remaining-dice count.
  - If the remaining count is now 0, go to DONE; otherwise go back to STROBE.
- **DONE**
  - `res_valid`=1; all `res_*` outputs are stable.
  - On `res_ready`, go to IDLE.
- Arithmetic:
  - The sum is unsigned and saturates at 2^SUM_W−1. It never wraps.
  - Min and max use unsigned 8-bit comparisons.
- Commands offered while busy are not accepted (`cmd_ready`=0). The offering side holds them.
- While in DONE, `cmd_valid` is ignored. The next command can be accepted no earlier than the cycle after the result handshake.

## Timing
- Reset values: `cmd_ready`=1, `roll`=0, `die_select`=00, `res_valid`=0, `res_sum`=0, `res_min`=0, `res_max`=0, `res_err`=0. State=IDLE.
- Each die costs 2+ROLL_LATENCY cycles: STROBE, ROLL_LATENCY cycles in WAIT, then CAPTURE.
- Command-accept edge to `res_valid` high: 1+N×(2+ROLL_LATENCY) cycles. For N=0 this is 1 cycle.
- All outputs are registered; there are no combinational paths from input to output.
- Reset asserted mid-command:
  - Every output returns to its reset value immediately.
  - Any `roll` pulse in progress is cut short.
  - The partial result is discarded.
- Within DONE, `res_valid` stays high until `res_ready` is seen. Holding `res_ready` high earlier does not skip DONE.

## Configuration
- `DICE_RANGE_CHECK_EN` defined:
  - In CAPTURE, `rolled_number`=0 or greater than the die's side count sets a sticky err flag.
  - `res_err` reports that flag.
  - The out-of-range value is still summed.
- `DICE_RANGE_CHECK_EN` undefined: there is no range-check logic and `res_err` is constant 0.

## Structure
- Shared package `dice_pkg`:
  - die-type encoding constants: `DIE_D4`, `DIE_D6`, `DIE_D8`, `DIE_D20`
  - the `sides_of(die)` function
  - the state enum.
- One sub-module, `dice_stats_acc`:
  - holds sum, min, max and err
  - inputs: clear, capture strobe, value, die.
- The FSM and latency counter stay in the top level.

## Test plan
- **Reset:** hold `reset_n`=0, then release.
  - Required: `cmd_ready`=1, `roll`=0, `res_valid`=0, all `res_*`=0.
- **Single die:** cmd d6, count=1; a stub `dice_roller` returns 4 after ROLL_LATENCY=1.
  - Required: exactly one `roll` pulse; `res_valid` 4 cycles after accept; sum=4, min=4, max=4.
- **Multiple dice:** cmd d20, count=3; stub returns 17, 3, 20.
  - Required: three `roll` pulses, 3 cycles apart; sum=40, min=3, max=20; `die_select`=11 throughout.
- **Zero count and backpressure:** cmd count=0.
  - Required: `res_valid` after 1 cycle with sum=0.
  - Then hold `res_ready`=0 for 5 cycles. Required: the result stays stable, `cmd_ready`=0, and a second `cmd_valid` is not accepted.
- **Reset mid-command:** cmd count=5; assert `reset_n`=0 during the second WAIT.
  - Required: `roll` drops to 0 at once and no result is produced.
  - A new count=1 command after release completes normally.
- **Range check (with `DICE_RANGE_CHECK_EN`):** cmd d4, count=2; stub returns 5, 2.
  - Required: `res_err`=1, sum=7.
  - Without the macro: `res_err`=0.
